// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller for a 5-stage in-order core.
// Freezes the whole pipe while instruction or data memory is busy,
// inserts a bubble on load-use hazards, flushes younger stages on a
// taken branch, and parks the core in a sticky HALTED state.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_MemToReg,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             branch_taken,
  input  logic             wb_Halt,
  output logic             pc_en,
  output logic             ifid_writeEN,
  output logic             idex_writeEN,
  output logic             exmem_writeEN,
  output logic             memwb_writeEN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IWAIT  = 2'd1,
    DWAIT  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t cur_state, nxt_state;
  logic   ihit_pend;

  logic dreq, dmem_ok, imem_ok, adv, lu, stall_evt;

  // Memory handshake and hazard qualifiers; dhit only matters when a data access is pending.
  always_comb begin
    dreq    = mem_dREN | mem_dWEN;
    dmem_ok = !dreq | dhit;
    imem_ok = ihit | ihit_pend;
    adv     = imem_ok & dmem_ok & (cur_state != HALTED);
    lu      = ex_MemToReg & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    // A halting cycle is not a stall: the core is stopping, not waiting.
    stall_evt = !RST && !wb_Halt && (cur_state != HALTED) && (!adv || (lu && !branch_taken));
  end

  // State register plus the sticky fetch-complete flag.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_state <= RUN;
      ihit_pend <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      // Remember a fetch that completed while the pipe was frozen so it is
      // not lost while the data side is still waiting.
      if (adv)       ihit_pend <= 1'b0;
      else if (ihit) ihit_pend <= 1'b1;
    end
  end

  // Next-state logic: halt is sticky; otherwise track which memory is holding us up.
  always_comb begin
    nxt_state = cur_state;
    if (cur_state == HALTED) begin
      nxt_state = HALTED;
    end else if (wb_Halt) begin
      nxt_state = HALTED;
    end else if (adv) begin
      nxt_state = RUN;
    end else if (dreq && !dhit && (cur_state == RUN || cur_state == IWAIT)) begin
      nxt_state = DWAIT;
    end else if (dmem_ok && !imem_ok && (cur_state == DWAIT || cur_state == RUN)) begin
      nxt_state = IWAIT;
    end
  end

  // Latch enables and flushes, in priority order reset > halt > freeze > branch > load-use.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pc_en         = 1'b0;
    ifid_writeEN  = 1'b0;
    idex_writeEN  = 1'b0;
    exmem_writeEN = 1'b0;
    memwb_writeEN = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    halt          = 1'b0;
    if (RST) begin
      halt = 1'b0;
    end else if (cur_state == HALTED || wb_Halt) begin
      halt = 1'b1;
    end else if (!adv) begin
      halt = 1'b0;
    end else if (branch_taken) begin
      // Squash the three younger instructions; the one retiring in WB stays.
      pc_en         = 1'b1;
      ifid_writeEN  = 1'b1;
      idex_writeEN  = 1'b1;
      exmem_writeEN = 1'b1;
      memwb_writeEN = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
    end else if (lu) begin
      // Hold PC and IF/ID, push a bubble into ID/EX, let the load move on.
      idex_writeEN  = 1'b1;
      idex_flush    = 1'b1;
      exmem_writeEN = 1'b1;
      memwb_writeEN = 1'b1;
    end else begin
      pc_en         = 1'b1;
      ifid_writeEN  = 1'b1;
      idex_writeEN  = 1'b1;
      exmem_writeEN = 1'b1;
      memwb_writeEN = 1'b1;
    end
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count <= '0;
    end else if (stall_evt && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver issues directed then random
// cycles and queues the expected response from a behavioural model; a
// monitor pops and compares on the falling edge.
module tb_pipeline_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst, ihit, dhit, rd, wr, mtr;
    logic [4:0] ert, rs, rt;
    logic       br, whalt;
  } stim_t;

  typedef struct packed {
    logic        pc_en;
    logic [3:0]  we;   // {ifid, idex, exmem, memwb}
    logic [3:0]  fl;
    logic        halt;
    logic [1:0]  state;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
  } exp_t;

  logic RST, ihit, dhit, mem_dREN, mem_dWEN, ex_MemToReg, branch_taken, wb_Halt;
  logic [4:0] ex_rt, id_rs, id_rt;

  logic pc_en, ifid_writeEN, idex_writeEN, exmem_writeEN, memwb_writeEN;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [1:0]  state;
  logic [15:0] stall_count;

  logic pc_en4, ifid_we4, idex_we4, exmem_we4, memwb_we4;
  logic ifid_fl4, idex_fl4, exmem_fl4, memwb_fl4, halt4;
  logic [1:0] state4;
  logic [3:0] stall_count4;

  pipeline_ctrl u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_MemToReg(ex_MemToReg),
    .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .branch_taken(branch_taken), .wb_Halt(wb_Halt),
    .pc_en(pc_en), .ifid_writeEN(ifid_writeEN), .idex_writeEN(idex_writeEN),
    .exmem_writeEN(exmem_writeEN), .memwb_writeEN(memwb_writeEN),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt(halt), .state(state), .stall_count(stall_count)
  );

  pipeline_ctrl #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_MemToReg(ex_MemToReg),
    .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .branch_taken(branch_taken), .wb_Halt(wb_Halt),
    .pc_en(pc_en4), .ifid_writeEN(ifid_we4), .idex_writeEN(idex_we4),
    .exmem_writeEN(exmem_we4), .memwb_writeEN(memwb_we4),
    .ifid_flush(ifid_fl4), .idex_flush(idex_fl4),
    .exmem_flush(exmem_fl4), .memwb_flush(memwb_fl4),
    .halt(halt4), .state(state4), .stall_count(stall_count4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: what the controller has observed so far, in plain terms.
  int m_state = 0;   // 0 run, 1 waiting on fetch, 2 waiting on data, 3 halted
  bit m_fetched = 0; // a fetch finished while the pipe was frozen
  int m_stalls = 0;  // unbounded stall tally; each counter width clips it

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit need_d, d_ready, i_ready, halted, go, hazard;
    need_d  = s.rd || s.wr;
    d_ready = !need_d || s.dhit;
    i_ready = s.ihit || m_fetched;
    halted  = (m_state == 3);
    go      = i_ready && d_ready && !halted;
    hazard  = s.mtr && s.ert != 0 && (s.ert == s.rs || s.ert == s.rt);
    e = '0;
    e.state = 2'(m_state);
    e.cnt16 = (m_stalls > 65535) ? 16'hffff : 16'(m_stalls);
    e.cnt4  = (m_stalls > 15) ? 4'hf : 4'(m_stalls);
    if (s.rst) begin
      e.halt = 0;
    end else if (halted || s.whalt) begin
      e.halt = 1;
    end else if (!go) begin
      e.halt = 0;
    end else if (s.br) begin
      e.pc_en = 1; e.we = 4'b1111; e.fl = 4'b1110;
    end else if (hazard) begin
      e.pc_en = 0; e.we = 4'b0111; e.fl = 4'b0100;
    end else begin
      e.pc_en = 1; e.we = 4'b1111; e.fl = 4'b0000;
    end
    return e;
  endfunction

  task automatic advance_model(input stim_t s);
    bit need_d, d_ready, i_ready, halted, go, hazard;
    need_d  = s.rd || s.wr;
    d_ready = !need_d || s.dhit;
    i_ready = s.ihit || m_fetched;
    halted  = (m_state == 3);
    go      = i_ready && d_ready && !halted;
    hazard  = s.mtr && s.ert != 0 && (s.ert == s.rs || s.ert == s.rt);
    if (s.rst) begin
      m_state = 0; m_fetched = 0; m_stalls = 0;
      return;
    end
    if (!halted && !s.whalt && (!go || (hazard && !s.br))) m_stalls++;
    if (go) m_fetched = 0;
    else if (s.ihit) m_fetched = 1;
    if (halted || s.whalt) m_state = 3;
    else if (go)           m_state = 0;
    else if (!d_ready)     m_state = 2;
    else if (!i_ready)     m_state = 1;
  endtask

  task automatic drive(input stim_t s);
    RST = s.rst; ihit = s.ihit; dhit = s.dhit; mem_dREN = s.rd; mem_dWEN = s.wr;
    ex_MemToReg = s.mtr; ex_rt = s.ert; id_rs = s.rs; id_rt = s.rt;
    branch_taken = s.br; wb_Halt = s.whalt;
  endtask

  // One checked cycle: drive just after the edge, queue the prediction.
  task automatic apply(input stim_t s);
    @(posedge CLK); #1;
    drive(s);
    sb_q.push_back(predict(s));
    advance_model(s);
  endtask

  // Monitor: compare everything the DUT presents against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("pc_en", 32'(pc_en), 32'(e.pc_en));
        check("writeEN", 32'({ifid_writeEN, idex_writeEN, exmem_writeEN, memwb_writeEN}), 32'(e.we));
        check("flush", 32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'(e.fl));
        check("halt", 32'(halt), 32'(e.halt));
        check("state", 32'(state), 32'(e.state));
        check("stall_count", 32'(stall_count), 32'(e.cnt16));
        check("stall_count_w4", 32'(stall_count4), 32'(e.cnt4));
      end
    end
  end

  initial begin
    stim_t s;
    int guard;
    // Power-up reset: state is unknown beforehand, so this cycle is not scored.
    s = '0; s.rst = 1;
    @(posedge CLK); #1; drive(s); advance_model(s);
    apply(s);                                  // outputs held low during reset

    // Clean streaming: fetch hits, no data access, no hazards.
    s = '0; s.ihit = 1;
    repeat (5) apply(s);

    // Load waits three cycles on data; fetch completed on the first.
    s = '0; s.rd = 1; s.ihit = 1;       apply(s);
    s.ihit = 0;                         apply(s); apply(s);
    s.dhit = 1;                         apply(s);
    s = '0; s.ihit = 1;                 apply(s);   // stall_count now 3

    // Load-use bubble, then the same shape with r0 as destination.
    s = '0; s.ihit = 1; s.mtr = 1; s.ert = 5; s.rs = 5; s.rt = 7; apply(s);
    s.ert = 0; s.rs = 0;                                            apply(s);
    // Branch overrides a load-use hazard.
    s = '0; s.ihit = 1; s.mtr = 1; s.ert = 5; s.rt = 5; s.br = 1;   apply(s);
    s = '0; s.ihit = 1;                                             apply(s);

    // Halt during a completing data access, linger, then reset out.
    s = '0; s.whalt = 1; s.rd = 1; s.dhit = 1; s.ihit = 1; apply(s);
    for (int i = 0; i < 10; i++) begin
      s = '0; s.ihit = 1'($urandom); s.br = 1'($urandom); s.mtr = 1; s.ert = 3; s.rs = 3;
      apply(s);
    end
    s = '0; s.rst = 1; s.ihit = 1; apply(s);
    s = '0; s.ihit = 1; apply(s);

    // Reset mid data-wait, then 20 freeze cycles to saturate the narrow counter.
    s = '0; s.rd = 1; s.ihit = 1; apply(s); apply(s);
    s = '0; s.rst = 1; apply(s);
    s = '0;
    repeat (20) apply(s);
    s.ihit = 1; apply(s);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.rst   = ($urandom_range(0, 99) == 0);
      s.whalt = ($urandom_range(0, 59) == 0);
      s.ihit  = ($urandom_range(0, 9) < 7);
      s.dhit  = ($urandom_range(0, 9) < 6);
      s.rd    = ($urandom_range(0, 9) < 3);
      s.wr    = !s.rd && ($urandom_range(0, 9) < 2);
      s.mtr   = ($urandom_range(0, 9) < 3);
      s.ert   = 5'($urandom_range(0, 3));
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.br    = ($urandom_range(0, 9) < 2);
      apply(s);
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall performance counter.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port ihit  input  1  instruction fetch complete this cycle.
REQ-005 SHALL have port dhit  input  1  data access complete this cycle.
REQ-006 SHALL have port mem_dREN / mem_dWEN  input  1 each  EX/MEM stage holds a load / store.
REQ-007 SHALL have port ex_MemToReg  input  1  ID/EX stage holds a load.
REQ-008 SHALL have port ex_rt, id_rs, id_rt  input  5 each  load destination, decode-stage sources.
REQ-009 SHALL have port branch_taken  input  1  taken branch/jump resolved in EX/MEM.
REQ-010 SHALL have port wb_Halt  input  1  MEM/WB latch Halt_out.
REQ-011 SHALL have port pc_en  output  1  PC update enable.
REQ-012 SHALL have ports {ifid,idex,exmem,memwb}_writeEN  output  1 each  latch enables.
REQ-013 SHALL have ports {ifid,idex,exmem,memwb}_flush  output  1 each  latch clears (bubble).
REQ-014 SHALL have port halt  output  1  sticky processor halted.
REQ-015 SHALL have port state  output  2  RUN=0, IWAIT=1, DWAIT=2, HALTED=3.
REQ-016 SHALL have port stall_count  output  CNT_W  stall-cycle counter.

Function
REQ-017 SHALL keep internal flag ihit_pend: set on ihit while adv=0, cleared on adv or RST.
REQ-018 SHALL define dreq = mem_dREN|mem_dWEN; dmem_ok = !dreq | dhit; imem_ok = ihit | ihit_pend; adv = imem_ok & dmem_ok & state!=HALTED.
REQ-019 SHALL ignore dhit when dreq=0.
REQ-020 SHALL, when adv=0 and not HALTED, drive pc_en and all writeEN and all flush to 0 (global freeze).
REQ-021 SHALL define lu = ex_MemToReg & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
REQ-022 SHALL, on adv with branch_taken: pc_en=1, all writeEN=1, ifid_flush=idex_flush=exmem_flush=1, memwb_flush=0.
REQ-023 SHALL, on adv with lu and !branch_taken: pc_en=0, ifid_writeEN=0, idex_writeEN=1 with idex_flush=1, exmem/memwb writeEN=1.
REQ-024 SHALL, on adv with neither: pc_en=1, all writeEN=1, all flush=0.
REQ-025 SHALL give priority: RST > wb_Halt > freeze (adv=0) > branch_taken > lu.
REQ-026 SHALL transition state: any non-HALTED -> HALTED when wb_Halt=1; RUN/IWAIT -> DWAIT when dreq & !dhit; DWAIT/RUN -> IWAIT when dmem_ok & !imem_ok; any -> RUN when adv; else hold.
REQ-027 SHALL, in HALTED, drive halt=1, pc_en=0, all writeEN=0, all flush=0, until RST.
REQ-028 SHALL assert halt combinationally the cycle wb_Halt=1, with all enables 0 that cycle.
REQ-029 SHALL increment stall_count by 1 each non-HALTED cycle where adv=0 or the lu bubble is inserted; saturate at all-ones.
REQ-030 SHALL not count branch flush cycles or HALTED cycles in stall_count.

Reset
REQ-031 SHALL, on RST=1 at a rising edge, set state=RUN, ihit_pend=0, halt=0, stall_count=0.
REQ-032 SHALL drive pc_en, all writeEN and all flush to 0 while RST=1, regardless of other inputs.
REQ-033 SHALL make RST mid-DWAIT or in HALTED return to RUN next cycle with no residual ihit_pend.

Verification
REQ-034 SHALL test: ihit=1, dreq=0, no hazards for 5 cycles -> pc_en=1, all writeEN=1, state=RUN, stall_count=0.
REQ-035 SHALL test: mem_dREN=1, ihit=1 at cycle 0, dhit=0 for 3 cycles then 1 -> freeze cycles 0-2, state=DWAIT, adv at cycle 3 via ihit_pend, stall_count=3.
REQ-036 SHALL test: ex_MemToReg=1, ex_rt=5, id_rs=5, ihit=1 -> pc_en=0, ifid_writeEN=0, idex_flush=1, stall_count+1; ex_rt=0 -> no bubble.
REQ-037 SHALL test: branch_taken=1 with lu=1, adv=1 -> ifid/idex/exmem flush=1, pc_en=1, stall_count unchanged.
REQ-038 SHALL test: wb_Halt=1 with dhit=1 -> halt=1, all enables 0, state=HALTED; held for 10 cycles; RST -> state=RUN, halt=0.
REQ-039 SHALL test: CNT_W=4, 20 freeze cycles -> stall_count saturates at 15.
